// File: rtl/traffic_pkg.sv
// Shared traffic-controller types: detector FSM states, lamp encoding and default constants.
package traffic_pkg;

    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        QUAL_ON  = 2'd1,
        PRESENT  = 2'd2,
        QUAL_OFF = 2'd3
    } detState_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    localparam int DEBOUNCE_DEFAULT = 8;
    localparam int SYNC_DEFAULT     = 2;

endpackage

// File: rtl/sync_chain.sv
// Parameterised N-flop synchroniser with asynchronous active-high reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/car_detector.sv
// Loop-sensor car detector: synchronise, debounce, latch the call until green, count arrivals.
// Optional stuck-sensor fail-safe is built when LOOP_FAULT_EN is defined.
module car_detector
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 8,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic             quartzClock,
    input  logic             reset,
    input  logic             loopRaw,
    input  logic             green,
    input  logic             yellow,
    input  logic             red,
    output logic             carDetected,
    output logic             presence,
    output logic [CNT_W-1:0] vehicleCount,
    output logic             loopFault
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    detState_t        state_r, nextState_s;
    logic [CW-1:0]    debCnt_r, nextCnt_s;
    logic             loopSync_s;
    logic             arrival_s, presenceNext_s, inPresent_s;
    logic             faultNext_s, carNext_s;
    logic [CNT_W-1:0] countNext_s;
    logic             carDetected_r, presence_r, loopFault_r;
    logic [CNT_W-1:0] vehicleCount_r;
    lamp_t            lamps_s;
    logic             unusedLamps_s;

    // Only green is decoded; the other lamps are carried for monitoring.
    assign lamps_s       = '{red: red, yellow: yellow, green: green};
    assign unusedLamps_s = lamps_s.red ^ lamps_s.yellow;

    sync_chain #(.STAGES(SYNC_STAGES)) uSync (
        .clk   (quartzClock),
        .reset (reset),
        .d     (loopRaw),
        .q     (loopSync_s)
    );

    // debounce state and counter registers
    always_ff @(posedge quartzClock or posedge reset) begin
        if (reset) begin
            state_r  <= ABSENT;
            debCnt_r <= CNT_ZERO;
        end else begin
            state_r  <= nextState_s;
            debCnt_r <= nextCnt_s;
        end
    end

    // debounce next-state and counter logic
    always_comb begin
        nextState_s = state_r;
        nextCnt_s   = debCnt_r;
        case (state_r)
            ABSENT: begin
                if (!loopSync_s) begin
                    nextCnt_s = CNT_ZERO;
                end else if (DEB_MAX == CNT_ONE) begin
                    nextState_s = PRESENT;
                    nextCnt_s   = CNT_ZERO;
                end else begin
                    nextState_s = QUAL_ON;
                    nextCnt_s   = CNT_ONE;
                end
            end
            QUAL_ON: begin
                if (!loopSync_s) begin
                    nextState_s = ABSENT;
                    nextCnt_s   = CNT_ZERO;
                end else if (debCnt_r + CNT_ONE == DEB_MAX) begin
                    nextState_s = PRESENT;
                    nextCnt_s   = CNT_ZERO;
                end else begin
                    nextCnt_s = debCnt_r + CNT_ONE;
                end
            end
            PRESENT: begin
                if (loopSync_s) begin
                    nextCnt_s = CNT_ZERO;
                end else if (DEB_MAX == CNT_ONE) begin
                    nextState_s = ABSENT;
                    nextCnt_s   = CNT_ZERO;
                end else begin
                    nextState_s = QUAL_OFF;
                    nextCnt_s   = CNT_ONE;
                end
            end
            QUAL_OFF: begin
                if (loopSync_s) begin
                    nextState_s = PRESENT;
                    nextCnt_s   = CNT_ZERO;
                end else if (debCnt_r + CNT_ONE == DEB_MAX) begin
                    nextState_s = ABSENT;
                    nextCnt_s   = CNT_ZERO;
                end else begin
                    nextCnt_s = debCnt_r + CNT_ONE;
                end
            end
            default: begin
                nextState_s = ABSENT;
                nextCnt_s   = CNT_ZERO;
            end
        endcase
    end

    // output decode: arrival pulse, presence, call latch and saturating count
    always_comb begin
        inPresent_s    = (state_r == PRESENT) || (state_r == QUAL_OFF);
        presenceNext_s = (nextState_s == PRESENT) || (nextState_s == QUAL_OFF);
        arrival_s      = !inPresent_s && (nextState_s == PRESENT);
        if (faultNext_s) begin
            carNext_s = 1'b1;
        end else if (lamps_s.green) begin
            carNext_s = 1'b0;
        end else if (arrival_s) begin
            carNext_s = 1'b1;
        end else begin
            carNext_s = carDetected_r;
        end
        if (arrival_s && (vehicleCount_r != {CNT_W{1'b1}})) begin
            countNext_s = vehicleCount_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            countNext_s = vehicleCount_r;
        end
    end

`ifdef LOOP_FAULT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);
    logic [SW-1:0] stuckCnt_r;

    // time spent with a vehicle present; saturates at the stuck threshold
    always_ff @(posedge quartzClock or posedge reset) begin
        if (reset) begin
            stuckCnt_r <= {SW{1'b0}};
        end else if (!inPresent_s) begin
            stuckCnt_r <= {SW{1'b0}};
        end else if (stuckCnt_r != STUCK_MAX) begin
            stuckCnt_r <= stuckCnt_r + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    assign faultNext_s = loopFault_r ||
                         (inPresent_s && (stuckCnt_r + {{(SW-1){1'b0}}, 1'b1} == STUCK_MAX));
`else
    localparam int unusedStuckCycles = STUCK_CYCLES;
    assign faultNext_s = 1'b0;
`endif

    // registered outputs
    always_ff @(posedge quartzClock or posedge reset) begin
        if (reset) begin
            carDetected_r  <= 1'b0;
            presence_r     <= 1'b0;
            loopFault_r    <= 1'b0;
            vehicleCount_r <= {CNT_W{1'b0}};
        end else begin
            carDetected_r  <= carNext_s;
            presence_r     <= presenceNext_s;
            loopFault_r    <= faultNext_s;
            vehicleCount_r <= countNext_s;
        end
    end

    assign carDetected  = carDetected_r;
    assign presence     = presence_r;
    assign loopFault    = loopFault_r;
    assign vehicleCount = vehicleCount_r;

endmodule

// File: tb/tb_car_detector.sv
// Directed self-checking bench for car_detector (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, STUCK_CYCLES=16).
module tb_car_detector;

    logic       quartzClock = 1'b0;
    logic       reset = 1'b1;
    logic       loopRaw = 1'b0;
    logic       green = 1'b0;
    logic       yellow = 1'b0;
    logic       red = 1'b0;
    logic       carDetected, presence, loopFault;
    logic [7:0] vehicleCount;
    int         errors = 0;
    int         checks = 0;

    car_detector #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(8), .STUCK_CYCLES(16)
    ) dut (
        .quartzClock (quartzClock),
        .reset       (reset),
        .loopRaw     (loopRaw),
        .green       (green),
        .yellow      (yellow),
        .red         (red),
        .carDetected (carDetected),
        .presence    (presence),
        .vehicleCount(vehicleCount),
        .loopFault   (loopFault)
    );

    always #5 quartzClock = ~quartzClock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge quartzClock);
            #1;
        end
    endtask

    task automatic apply_reset();
        loopRaw = 1'b0; green = 1'b0; yellow = 1'b0; red = 1'b1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (presence !== 1'b0) begin $display("FAIL reset_presence: got %b expected 0", presence); errors++; end
        checks++; if (carDetected !== 1'b0) begin $display("FAIL reset_car: got %b expected 0", carDetected); errors++; end
        checks++; if (vehicleCount !== 8'd0) begin $display("FAIL reset_count: got %0d expected 0", vehicleCount); errors++; end
        checks++; if (loopFault !== 1'b0) begin $display("FAIL reset_fault: got %b expected 0", loopFault); errors++; end
    endtask

    // Reset lands mid-qualify, then a fresh arrival under red and service by green.
    task automatic test_reset_mid_qual_and_arrival();
        apply_reset();
        loopRaw = 1'b1;
        tick(3);
        reset = 1'b1;
        #2;
        checks++; if ({presence, carDetected, vehicleCount, loopFault} !== 11'd0) begin
            $display("FAIL midqual_async: got %b expected 0", {presence, carDetected, vehicleCount, loopFault}); errors++; end
        reset = 1'b0;
        tick(5);
        checks++; if (presence !== 1'b0) begin $display("FAIL midqual_early: got %b expected 0", presence); errors++; end
        tick(1);
        checks++; if (presence !== 1'b1) begin $display("FAIL arrival_presence: got %b expected 1", presence); errors++; end
        checks++; if (carDetected !== 1'b1) begin $display("FAIL arrival_car: got %b expected 1", carDetected); errors++; end
        checks++; if (vehicleCount !== 8'd1) begin $display("FAIL arrival_count: got %0d expected 1", vehicleCount); errors++; end
        green = 1'b1; red = 1'b0;
        tick(1);
        checks++; if (carDetected !== 1'b0) begin $display("FAIL green_clear: got %b expected 0", carDetected); errors++; end
        green = 1'b0; red = 1'b1; loopRaw = 1'b0;
        tick(5);
        checks++; if (presence !== 1'b1) begin $display("FAIL depart_early: got %b expected 1", presence); errors++; end
        tick(1);
        checks++; if (presence !== 1'b0) begin $display("FAIL depart_presence: got %b expected 0", presence); errors++; end
        checks++; if (carDetected !== 1'b0) begin $display("FAIL depart_car: got %b expected 0", carDetected); errors++; end
    endtask

    task automatic test_glitch();
        apply_reset();
        loopRaw = 1'b1;
        tick(3);
        loopRaw = 1'b0;
        tick(10);
        checks++; if (presence !== 1'b0) begin $display("FAIL glitch_presence: got %b expected 0", presence); errors++; end
        checks++; if (carDetected !== 1'b0) begin $display("FAIL glitch_car: got %b expected 0", carDetected); errors++; end
        checks++; if (vehicleCount !== 8'd0) begin $display("FAIL glitch_count: got %0d expected 0", vehicleCount); errors++; end
    endtask

    task automatic test_green_arrival();
        apply_reset();
        green = 1'b1; red = 1'b0; loopRaw = 1'b1;
        tick(6);
        checks++; if (presence !== 1'b1) begin $display("FAIL garr_presence: got %b expected 1", presence); errors++; end
        checks++; if (vehicleCount !== 8'd1) begin $display("FAIL garr_count: got %0d expected 1", vehicleCount); errors++; end
        checks++; if (carDetected !== 1'b0) begin $display("FAIL garr_car: got %b expected 0", carDetected); errors++; end
        loopRaw = 1'b0;
        tick(6);
        green = 1'b0; red = 1'b1;
        tick(3);
        checks++; if (presence !== 1'b0) begin $display("FAIL garr_depart: got %b expected 0", presence); errors++; end
        checks++; if (carDetected !== 1'b0) begin $display("FAIL garr_red_car: got %b expected 0", carDetected); errors++; end
    endtask

    task automatic test_departure_before_service();
        apply_reset();
        loopRaw = 1'b1;
        tick(6);
        checks++; if (carDetected !== 1'b1) begin $display("FAIL dbs_set: got %b expected 1", carDetected); errors++; end
        loopRaw = 1'b0;
        tick(9);
        checks++; if (presence !== 1'b0) begin $display("FAIL dbs_presence: got %b expected 0", presence); errors++; end
        checks++; if (carDetected !== 1'b1) begin $display("FAIL dbs_memory: got %b expected 1", carDetected); errors++; end
        // illegal lamp mix without green keeps the call
        yellow = 1'b1;
        tick(1);
        checks++; if (carDetected !== 1'b1) begin $display("FAIL dbs_illegal_hold: got %b expected 1", carDetected); errors++; end
        green = 1'b1;
        tick(1);
        checks++; if (carDetected !== 1'b0) begin $display("FAIL dbs_illegal_clear: got %b expected 0", carDetected); errors++; end
    endtask

    task automatic test_saturation();
        apply_reset();
        green = 1'b1; red = 1'b0;
        for (int i = 0; i < 256; i++) begin
            loopRaw = 1'b1;
            tick(6);
            loopRaw = 1'b0;
            tick(6);
            if (i == 254) begin
                checks++; if (vehicleCount !== 8'd255) begin $display("FAIL sat_255: got %0d expected 255", vehicleCount); errors++; end
            end
        end
        checks++; if (vehicleCount !== 8'd255) begin $display("FAIL sat_nowrap: got %0d expected 255", vehicleCount); errors++; end
    endtask

    task automatic test_fault();
        apply_reset();
        green = 1'b1; red = 1'b0; loopRaw = 1'b1;
`ifdef LOOP_FAULT_EN
        tick(21);
        checks++; if (loopFault !== 1'b0) begin $display("FAIL fault_early: got %b expected 0", loopFault); errors++; end
        tick(1);
        checks++; if (loopFault !== 1'b1) begin $display("FAIL fault_set: got %b expected 1", loopFault); errors++; end
        checks++; if (carDetected !== 1'b1) begin $display("FAIL fault_recall: got %b expected 1", carDetected); errors++; end
        loopRaw = 1'b0;
        tick(10);
        checks++; if ({loopFault, carDetected} !== 2'b11) begin $display("FAIL fault_sticky: got %b expected 11", {loopFault, carDetected}); errors++; end
`else
        tick(40);
        checks++; if (loopFault !== 1'b0) begin $display("FAIL fault_tied: got %b expected 0", loopFault); errors++; end
        checks++; if (carDetected !== 1'b0) begin $display("FAIL fault_nocall: got %b expected 0", carDetected); errors++; end
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid_qual_and_arrival();
        test_glitch();
        test_green_arrival();
        test_departure_before_service();
        test_saturation();
        test_fault();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
